// File: rtl/sw_array_ctrl.sv
// Job controller for the Smith-Waterman linear PE array: buffers the host query,
// replays it over the save-s chain, streams the target through PE0, drains and captures the score.
module sw_array_ctrl #(
    parameter int         N_PE    = 8,
    parameter int         LW      = 4,
    parameter int         TW      = 8,
    parameter logic [1:0] PAD_SYM = 2'd0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [LW-1:0] i_s_len,
    input  logic [TW-1:0] i_t_len,
    input  logic          i_sym_valid,
    input  logic [1:0]    i_sym_data,
    output logic          o_sym_ready,
    output logic          o_pe_enable,
    output logic          o_save_s,
    output logic [1:0]    o_s_bus,
    output logic [1:0]    o_t_feed,
    input  logic [11:0]   i_max_last,
    output logic [11:0]   o_score,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);
    localparam int DW = $clog2(N_PE + 1);

    localparam logic [LW-1:0] L_ZERO = '0;
    localparam logic [LW-1:0] L_ONE  = LW'(1);
    localparam logic [LW-1:0] L_NPE  = LW'(N_PE);
    localparam logic [TW-1:0] T_ZERO = '0;
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [DW-1:0] D_ZERO = '0;
    localparam logic [DW-1:0] D_ONE  = DW'(1);
    localparam logic [DW-1:0] D_INIT = DW'(N_PE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QFILL,
        S_LOAD,
        S_FLUSH,
        S_STREAM,
        S_DRAIN
    } state_t;

    state_t        r_state, w_state;
    logic [LW-1:0] r_s_len, w_s_len;
    logic [TW-1:0] r_t_len, w_t_len;
    logic [LW-1:0] r_idx, w_idx;
    logic [TW-1:0] r_tcnt, w_tcnt;
    logic [DW-1:0] r_dcnt, w_dcnt;
    logic [1:0]    r_qbuf [0:(1<<LW)-1];

    logic          r_sym_ready, w_sym_ready;
    logic          r_pe_enable, w_pe_enable;
    logic          r_save_s, w_save_s;
    logic [1:0]    r_s_bus, w_s_bus;
    logic [1:0]    r_t_feed, w_t_feed;
    logic [11:0]   r_score, w_score;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_err, w_err;

    logic          w_hs;
    logic          w_len_ok;
    logic          w_qbuf_we;

    assign w_hs     = i_sym_valid & r_sym_ready;
    assign w_len_ok = (i_s_len != L_ZERO) && (i_s_len <= L_NPE) && (i_t_len != T_ZERO);

    always_comb begin
        w_state     = r_state;
        w_s_len     = r_s_len;
        w_t_len     = r_t_len;
        w_idx       = r_idx;
        w_tcnt      = r_tcnt;
        w_dcnt      = r_dcnt;
        w_sym_ready = 1'b0;
        w_pe_enable = 1'b0;
        w_save_s    = 1'b0;
        w_s_bus     = 2'd0;
        w_t_feed    = PAD_SYM;
        w_score     = r_score;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_err       = r_err;
        w_qbuf_we   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_len_ok) begin
                        w_s_len     = i_s_len;
                        w_t_len     = i_t_len;
                        w_err       = 1'b0;
                        w_idx       = L_ZERO;
                        w_state     = S_QFILL;
                        w_sym_ready = 1'b1;
                        w_busy      = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            S_QFILL: begin
                w_busy      = 1'b1;
                w_sym_ready = 1'b1;
                if (w_hs) begin
                    w_qbuf_we = 1'b1;
                    if (r_idx == r_s_len - L_ONE) begin
                        // entry 0 is still being written when the query is a single symbol
                        w_state     = S_LOAD;
                        w_sym_ready = 1'b0;
                        w_pe_enable = 1'b1;
                        w_save_s    = 1'b1;
                        w_s_bus     = (r_s_len == L_ONE) ? i_sym_data : r_qbuf[L_ZERO];
                        w_idx       = L_ONE;
                    end else begin
                        w_idx = r_idx + L_ONE;
                    end
                end
            end
            S_LOAD: begin
                w_busy = 1'b1;
                if (r_idx == r_s_len) begin
                    w_state     = S_FLUSH;
                    w_idx       = L_ZERO;
                    w_sym_ready = 1'b1;
                end else begin
                    w_pe_enable = 1'b1;
                    w_save_s    = 1'b1;
                    w_s_bus     = r_qbuf[r_idx];
                    w_idx       = r_idx + L_ONE;
                end
            end
            S_FLUSH, S_STREAM: begin
                if (!w_hs) begin
                    w_state = S_IDLE;
                    w_err   = 1'b1;
                end else begin
                    w_t_feed    = i_sym_data;
                    w_busy      = 1'b1;
                    w_pe_enable = 1'b1;
                    // r_tcnt counts target symbols still owed after this accept
                    if ((r_state == S_FLUSH && r_t_len == T_ONE) ||
                        (r_state == S_STREAM && r_tcnt == T_ONE)) begin
                        w_state = S_DRAIN;
                        w_dcnt  = D_INIT;
                    end else begin
                        w_state     = S_STREAM;
                        w_sym_ready = 1'b1;
                        w_tcnt      = (r_state == S_FLUSH) ? r_t_len - T_ONE : r_tcnt - T_ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (r_dcnt == D_ZERO) begin
                    w_state = S_IDLE;
                    w_score = i_max_last;
                    w_done  = 1'b1;
                end else begin
                    w_dcnt      = r_dcnt - D_ONE;
                    w_pe_enable = 1'b1;
                    w_busy      = 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_s_len     <= '0;
            r_t_len     <= '0;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_dcnt      <= '0;
            r_sym_ready <= 1'b0;
            r_pe_enable <= 1'b0;
            r_save_s    <= 1'b0;
            r_s_bus     <= 2'd0;
            r_t_feed    <= PAD_SYM;
            r_score     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_s_len     <= w_s_len;
            r_t_len     <= w_t_len;
            r_idx       <= w_idx;
            r_tcnt      <= w_tcnt;
            r_dcnt      <= w_dcnt;
            r_sym_ready <= w_sym_ready;
            r_pe_enable <= w_pe_enable;
            r_save_s    <= w_save_s;
            r_s_bus     <= w_s_bus;
            r_t_feed    <= w_t_feed;
            r_score     <= w_score;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_qbuf_we) begin
            r_qbuf[r_idx] <= i_sym_data;
        end
    end

    assign o_sym_ready = r_sym_ready;
    assign o_pe_enable = r_pe_enable;
    assign o_save_s    = r_save_s;
    assign o_s_bus     = r_s_bus;
    assign o_t_feed    = r_t_feed;
    assign o_score     = r_score;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: doc/sw_array_ctrl.md
# sw_array_ctrl

Job controller for the Smith-Waterman linear PE array. It collects a query sequence from the host through a valid/ready handshake and buffers it internally. It then replays the query into the array over the save-s chain, streams the target sequence through PE0, drains the pipeline, and captures the alignment score from the last PE's max output. It sits between the host symbol stream and the broadcast and PE0-side inputs of the array.

## Interface
- N_PE, default 8: number of PEs in the array, which is also the maximum query length.
- LW, default 4: width of s_len; 2^LW must be greater than N_PE.
- TW, default 8: width of t_len.
- PAD_SYM, default 2'd0: symbol driven on t_feed when no target symbol is present.
- clk, in, 1: single clock; all logic is on the rising edge.
- reset, in, 1: asynchronous, active-low; 0 resets the whole block immediately.
- start, in, 1: job request; sampled only in IDLE.
- s_len, in, LW: query length; legal range 1..N_PE; latched on an accepted start.
- t_len, in, TW: target length; legal range 1..2^TW-1; latched on an accepted start.
- sym_valid, in, 1: host symbol valid.
- sym_data, in, 2: host symbol.
- sym_ready, out, 1: controller accepts a symbol this cycle.
- pe_enable, out, 1: to pe_enable of every PE.
- save_s, out, 1: to save_s_in of PE0.
- s_bus, out, 2: query symbol broadcast to s_in of every PE.
- t_feed, out, 2: to t_in of PE0.
- max_last, in, 12: max_out of PE N_PE-1.
- score, out, 12: captured alignment score.
- busy, out, 1: a job is in progress.
- done, out, 1: one-cycle completion pulse.
- err, out, 1: sticky error flag; cleared by the next accepted start.

## Operation
- All outputs are registered. Reset value of every output is 0, except t_feed, which resets to PAD_SYM.
- A handshake occurs when sym_valid and sym_ready are both 1 in the same cycle.
- FSM states: IDLE, QFILL, LOAD, FLUSH, STREAM, DRAIN.
- **IDLE**
  - start=1 with legal lengths: latch the lengths, clear err, go to QFILL, busy=1.
  - start=1 with s_len=0, s_len>N_PE, or t_len=0: err=1 and stay in IDLE.
  - start is ignored in every state other than IDLE.
- **QFILL**
  - sym_ready=1.
  - Each handshake writes the query buffer entry qbuf[idx], then idx++.
  - sym_valid gaps are allowed here.
  - After the s_len-th handshake, go to LOAD.
- **LOAD** (exactly s_len cycles, i = 0..s_len-1)
  - pe_enable=1, save_s=1, s_bus=qbuf[i], t_feed=PAD_SYM.
- **FLUSH** (1 cycle)
  - pe_enable=0, save_s=0, s_bus=0. This clears the PE datapath state; query symbols stay held.
  - sym_ready=1, so target symbol 0 is accepted here.
- **STREAM** (t_len-1 cycles)
  - sym_ready=1 and pe_enable=1.
  - The target must arrive contiguously, starting in FLUSH.
- t_feed rule: t_feed equals the symbol accepted in the previous cycle; otherwise it is PAD_SYM.
- **Underflow**: sym_valid=0 in FLUSH or STREAM is an error.
  - Next cycle: err=1, pe_enable=0, sym_ready=0, busy=0, state IDLE.
  - No done pulse; score is unchanged.
- **DRAIN** (exactly N_PE+1 cycles)
  - pe_enable=1, sym_ready=0.
  - t_feed carries the last target symbol in the first DRAIN cycle, then PAD_SYM.
  - In the last DRAIN cycle, score <= max_last.
  - Then go to IDLE with done=1 for one cycle and busy=0.
- score holds its value until the next job captures a new one.
- Counters are sized for N_PE+1 and 2^TW-1 and never wrap within a legal job.

## Timing
- Accepted start at edge E: the controller is in QFILL with sym_ready=1 from cycle E+1.
- Query phase: the last query handshake in cycle Q is followed by LOAD cycles Q+1..Q+s_len.
- FLUSH occurs in cycle Q+s_len+1.
- Target handshakes occur in cycles F..F+t_len-1, where F is the FLUSH cycle.
- Last target accept in cycle A:
  - DRAIN spans A+1..A+N_PE+1.
  - done=1 in cycle A+N_PE+2.
  - score is valid from cycle A+N_PE+2 onward.
- Back-to-back jobs: start may be asserted in the same cycle as done; QFILL then begins in the next cycle.
- Reset asserted in any state, including mid-LOAD or mid-STREAM:
  - All outputs return to reset values immediately; pe_enable drops asynchronously.
  - err and score are cleared and the query buffer index returns to 0.
  - After reset releases, the controller sits in IDLE.

## Test plan
1. Reset with outputs toggling, then release -> every output is 0, t_feed=PAD_SYM, and the FSM is in IDLE; start is honoured in the first cycle after release.
2. N_PE=4; s_len=3; query 1,2,3 sent with one-cycle sym_valid gaps -> three handshakes, then save_s=1 for exactly 3 cycles with s_bus=1,2,3 and pe_enable=1, then one FLUSH cycle with pe_enable=0.
3. t_len=5; target 0,1,2,3,0 sent contiguously; max_last forced to 12'd42 -> t_feed=0,1,2,3,0 on the cycles after each accept; done pulses exactly 6 cycles after the last accept; score=42; busy falls with done.
4. sym_valid dropped on the 3rd target cycle -> err=1, pe_enable=0 and busy=0 the next cycle; no done pulse; score unchanged; the next legal start clears err.
5. start with s_len=0, then s_len=5, then t_len=0 -> err=1 each time; sym_ready never rises; busy stays 0.
6. start pulsed during STREAM -> ignored, job completes normally. In a second run, reset driven low mid-STREAM -> pe_enable=0 within the same cycle, FSM in IDLE, and a fresh job then completes with the correct timing.
